// File: rtl/tm1638_disp_arb_if.sv
// -----------------------------------------------------------------------------
// tm1638_disp_arb_if
//
// Bundle of every non-clock signal between the display arbiter, its two
// clients and the shared TM1638 LED/key driver.
//
// Signal summary (directions as seen by the arbiter, modport 'slave'):
//   FRAME_i             in   1   one-cycle strobe per driver frame
//   KEYS_i              in   8   driver key levels
//   REQ_B_i             in   1   client B requests the display (level)
//   A_BIN_DAT_i         in  32   client A hex digits, 8 x 4 bit
//   A_DOTS_i            in   8   client A decimal points
//   A_LEDS_i            in   8   client A discrete LEDs
//   A_ENCBIN_XDIRECT_i  in   1   client A encode mode
//   B_*                 in       same fields for client B
//   BIN_DAT_o           out 32   to driver BIN_DAT_i
//   DOTS_o              out  8   to driver DOTS_i
//   LEDS_o              out  8   to driver LEDS_i
//   ENCBIN_XDIRECT_o    out  1   to driver ENCBIN_XDIRECT_i
//   OWNER_o             out  1   0 = A owns, 1 = B owns
//   GNT_B_o             out  1   B holds the grant
//   KEY_PRS_A_o         out  8   one-cycle press pulses for A
//   KEY_PRS_B_o         out  8   one-cycle press pulses for B
//
// Modport 'master' is the environment side (clients plus driver).
// -----------------------------------------------------------------------------
interface tm1638_disp_arb_if;
  logic        FRAME_i;
  logic [7:0]  KEYS_i;
  logic        REQ_B_i;

  logic [31:0] A_BIN_DAT_i;
  logic [7:0]  A_DOTS_i;
  logic [7:0]  A_LEDS_i;
  logic        A_ENCBIN_XDIRECT_i;

  logic [31:0] B_BIN_DAT_i;
  logic [7:0]  B_DOTS_i;
  logic [7:0]  B_LEDS_i;
  logic        B_ENCBIN_XDIRECT_i;

  logic [31:0] BIN_DAT_o;
  logic [7:0]  DOTS_o;
  logic [7:0]  LEDS_o;
  logic        ENCBIN_XDIRECT_o;
  logic        OWNER_o;
  logic        GNT_B_o;
  logic [7:0]  KEY_PRS_A_o;
  logic [7:0]  KEY_PRS_B_o;

  modport slave (
    input  FRAME_i, KEYS_i, REQ_B_i,
    input  A_BIN_DAT_i, A_DOTS_i, A_LEDS_i, A_ENCBIN_XDIRECT_i,
    input  B_BIN_DAT_i, B_DOTS_i, B_LEDS_i, B_ENCBIN_XDIRECT_i,
    output BIN_DAT_o, DOTS_o, LEDS_o, ENCBIN_XDIRECT_o,
    output OWNER_o, GNT_B_o, KEY_PRS_A_o, KEY_PRS_B_o
  );

  modport master (
    output FRAME_i, KEYS_i, REQ_B_i,
    output A_BIN_DAT_i, A_DOTS_i, A_LEDS_i, A_ENCBIN_XDIRECT_i,
    output B_BIN_DAT_i, B_DOTS_i, B_LEDS_i, B_ENCBIN_XDIRECT_i,
    input  BIN_DAT_o, DOTS_o, LEDS_o, ENCBIN_XDIRECT_o,
    input  OWNER_o, GNT_B_o, KEY_PRS_A_o, KEY_PRS_B_o
  );
endinterface

// File: rtl/tm1638_disp_arb.sv
// -----------------------------------------------------------------------------
// tm1638_disp_arb
//
// Frame-synchronous arbiter sharing one TM1638 LED/key driver between a
// background client A (status display) and an on-demand overlay client B
// (menu, alert). Ownership only changes on the driver frame strobe so that a
// frame never mixes content of both clients. Key presses are turned into
// one-cycle edge pulses and routed to the current owner only.
//
// Parameters:
//   C_HOLD_FRAMES  frames B keeps ownership after REQ_B_i falls (0 = release
//                  at the next frame)
//   C_CNT_W        linger counter width, 2**C_CNT_W must exceed C_HOLD_FRAMES
//
// Ports:
//   CK_i     system clock (single clock domain)
//   XARST_i  asynchronous active-low reset
//   bus      tm1638_disp_arb_if.slave, see the interface file for fields
// -----------------------------------------------------------------------------
module tm1638_disp_arb #(
  parameter int unsigned C_HOLD_FRAMES = 250,
  parameter int unsigned C_CNT_W       = 8
) (
  input  logic                    CK_i,
  input  logic                    XARST_i,
  tm1638_disp_arb_if.slave        bus
);

  typedef enum logic [1:0] {
    ST_A      = 2'd0,  // A owns, no request pending
    ST_PEND_B = 2'd1,  // A still owns, B waits for the next frame strobe
    ST_B      = 2'd2   // B owns, linger counter runs once B goes quiet
  } state_t;

  // Everything that is forwarded to the driver for one frame.
  typedef struct packed {
    logic [31:0] bin_dat;
    logic [7:0]  dots;
    logic [7:0]  leds;
    logic        encbin_xdirect;
  } disp_t;

  localparam logic [C_CNT_W-1:0] HOLD_CNT = C_CNT_W'(C_HOLD_FRAMES);

  state_t             state_q, state_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]         keys_d_q;
  logic [7:0]         prs;
  logic [7:0]         prs_a_q, prs_b_q;
  logic               owner;
  logic               b_active;
  disp_t              a_disp, b_disp, disp_q;

  // ---------------------------------------------------------------------------
  // Key edge detection
  // ---------------------------------------------------------------------------
  // Rising edges only; release events are deliberately not reported.
  assign prs = bus.KEYS_i & ~keys_d_q;

  // Activity that keeps B alive. In ST_B every press belongs to B, so the
  // unrouted press vector is sufficient here.
  assign b_active = bus.REQ_B_i | (|prs);

  // Ownership is a pure decode of the state register, hence glitch-free and
  // registered.
  assign owner = (state_q == ST_B);

  assign a_disp = '{bin_dat:        bus.A_BIN_DAT_i,
                    dots:           bus.A_DOTS_i,
                    leds:           bus.A_LEDS_i,
                    encbin_xdirect: bus.A_ENCBIN_XDIRECT_i};

  assign b_disp = '{bin_dat:        bus.B_BIN_DAT_i,
                    dots:           bus.B_DOTS_i,
                    leds:           bus.B_LEDS_i,
                    encbin_xdirect: bus.B_ENCBIN_XDIRECT_i};

  // ---------------------------------------------------------------------------
  // FSM: next state and linger counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_A: begin
        // The request is taken immediately, even on a frame edge; the grant
        // itself always waits for the following strobe.
        if (bus.REQ_B_i) begin
          state_d = ST_PEND_B;
        end
      end

      ST_PEND_B: begin
        if (bus.FRAME_i) begin
          if (bus.REQ_B_i) begin
            state_d = ST_B;
            cnt_d   = HOLD_CNT;
          end else begin
            // Request dropped before any frame: cancelled.
            state_d = ST_A;
          end
        end
      end

      ST_B: begin
        // Reload beats both decrement and release.
        if (b_active) begin
          cnt_d = HOLD_CNT;
        end else if (bus.FRAME_i) begin
          if (cnt_q == '0) begin
            state_d = ST_A;
          end else begin
            cnt_d = cnt_q - C_CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_A;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counter and key registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state_q  <= ST_A;
      cnt_q    <= '0;
      keys_d_q <= '0;
      prs_a_q  <= '0;
      prs_b_q  <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      keys_d_q <= bus.KEYS_i;
      // Routing uses the owner from before this edge: a press coinciding
      // with a switch goes to the outgoing owner.
      prs_a_q  <= owner ? 8'h00 : prs;
      prs_b_q  <= owner ? prs   : 8'h00;
    end
  end

  // ---------------------------------------------------------------------------
  // Display registers: load only on frame strobes, from the client selected
  // by the next state, so each frame carries content of exactly one client.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      // NOTE: the display path is a handful of plain flops, not a memory, so
      // it is cleared by reset like the rest of the control state.
      disp_q <= '0;
    end else if (bus.FRAME_i) begin
      disp_q <= (state_d == ST_B) ? b_disp : a_disp;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.BIN_DAT_o        = disp_q.bin_dat;
  assign bus.DOTS_o           = disp_q.dots;
  assign bus.LEDS_o           = disp_q.leds;
  assign bus.ENCBIN_XDIRECT_o = disp_q.encbin_xdirect;
  assign bus.OWNER_o          = owner;
  assign bus.GNT_B_o          = owner;
  assign bus.KEY_PRS_A_o      = prs_a_q;
  assign bus.KEY_PRS_B_o      = prs_b_q;

endmodule
